combo_lock_param: RTL and testbench

- Parametrised successor to the keypad combination-lock core.
- Takes synchronised keypad code/valid inputs, debounces them, and buffers a DIGITS-long entry with backspace and clear.
- Stores or checks the passcode, counts failed attempts, and enforces a timed lockout after MAX_FAILS consecutive failures.
- Exports the raw entry nibbles and status; seven-segment encoding lives in a separate display block.

---
 rtl/combo_lock_param.sv | 143 ++++++++++++++
 tb/tb_combo_lock_param.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_param.sv
// Keypad combination-lock core: debounced key capture, entry buffer,
// passcode store/check, failed-attempt counting and timed lockout.
module combo_lock_param #(
  parameter int DIGITS = 6,
  parameter int DEBOUNCE_CYCLES = 12_500_000,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 250_000_000,
  parameter logic [4*DIGITS-1:0] RESET_CODE = 24'h123456
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   key_code_sync,
  input  logic                         key_validn_sync,
  output logic [4*DIGITS-1:0]          entry,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         locked,
  output logic                         lockout,
  output logic [3:0]                   fail_count,
  output logic                         key_pressed,
  output logic                         debounce_active,
  output logic                         unlock_pulse,
  output logic                         bad_pulse
);

  localparam int CW = $clog2(DIGITS+1);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (LOCKOUT_CYCLES > 1) ?
                      $clog2(LOCKOUT_CYCLES+1) : 1;

  typedef enum logic [1:0] {
    S_OPEN,
    S_LOCKED,
    S_LOCKOUT
  } state_t;

  state_t               state;
  logic [4*DIGITS-1:0]  passcode;
  logic [3:0]           key_q;
  logic [DW-1:0]        deb_cnt;
  logic [TW-1:0]        timer;
  logic                 validn_prev;
  logic                 accept;
  logic                 full;

  assign accept  = validn_prev & ~key_validn_sync & ~debounce_active;
  assign full    = (digit_count == CW'(DIGITS));
  assign locked  = (state != S_OPEN);
  assign lockout = (state == S_LOCKOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_OPEN;
      entry           <= '1;
      digit_count     <= '0;
      passcode        <= RESET_CODE;
      fail_count      <= '0;
      key_pressed     <= 1'b0;
      key_q           <= '0;
      debounce_active <= 1'b0;
      deb_cnt         <= '0;
      timer           <= '0;
      validn_prev     <= 1'b1;
      unlock_pulse    <= 1'b0;
      bad_pulse       <= 1'b0;
    end else begin
      validn_prev  <= key_validn_sync;
      key_pressed  <= accept;
      unlock_pulse <= 1'b0;
      bad_pulse    <= 1'b0;

      if (accept) begin
        key_q           <= key_code_sync;
        debounce_active <= 1'b1;
        deb_cnt         <= '0;
      end else if (debounce_active) begin
        if (deb_cnt == DW'(DEBOUNCE_CYCLES-1))
          debounce_active <= 1'b0;
        else
          deb_cnt <= deb_cnt + 1'b1;
      end

      // Keys captured last cycle act now; lockout only runs its timer.
      if (state == S_LOCKOUT) begin
        if (timer == TW'(1)) begin
          state      <= S_LOCKED;
          fail_count <= '0;
          timer      <= '0;
        end else begin
          timer <= timer - 1'b1;
        end
      end else if (key_pressed) begin
        unique case (1'b1)
          (key_q <= 4'hC): begin
            if (!full) begin
              for (int i = 0; i < DIGITS; i++)
                if (i == int'(digit_count))
                  entry[4*(DIGITS-1-i) +: 4] <= key_q;
              digit_count <= digit_count + 1'b1;
            end
          end
          (key_q == 4'hD): begin
            if (digit_count != '0) begin
              for (int i = 0; i < DIGITS; i++)
                if (i == int'(digit_count) - 1)
                  entry[4*(DIGITS-1-i) +: 4] <= 4'hF;
              digit_count <= digit_count - 1'b1;
            end
          end
          (key_q == 4'hF): begin
            entry       <= '1;
            digit_count <= '0;
          end
          (key_q == 4'hE): begin
            if (full) begin
              entry       <= '1;
              digit_count <= '0;
              if (state == S_OPEN) begin
                passcode   <= entry;
                state      <= S_LOCKED;
                fail_count <= '0;
              end else if (entry == passcode) begin
                state        <= S_OPEN;
                fail_count   <= '0;
                unlock_pulse <= 1'b1;
              end else begin
                bad_pulse <= 1'b1;
                if (fail_count + 4'd1 == 4'(MAX_FAILS)) begin
                  state      <= S_LOCKOUT;
                  fail_count <= 4'(MAX_FAILS);
                  timer      <= TW'(LOCKOUT_CYCLES);
                end else begin
                  fail_count <= fail_count + 4'd1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_combo_lock_param.sv
// Bench for combo_lock_param: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random keys.
module tb_combo_lock_param;

  localparam int DIGITS = 4;
  localparam int DEB    = 4;
  localparam int MAXF   = 2;
  localparam int LOCKC  = 10;
  localparam logic [15:0] RC = 16'h1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  code = 4'h0;
  logic        validn = 1'b1;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        locked, lockout;
  logic [3:0]  fail_count;
  logic        key_pressed, debounce_active;
  logic        unlock_pulse, bad_pulse;

  always #5 clk = ~clk;

  combo_lock_param #(
    .DIGITS(DIGITS),
    .DEBOUNCE_CYCLES(DEB),
    .MAX_FAILS(MAXF),
    .LOCKOUT_CYCLES(LOCKC),
    .RESET_CODE(RC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_code_sync(code),
    .key_validn_sync(validn),
    .entry(entry),
    .digit_count(digit_count),
    .locked(locked),
    .lockout(lockout),
    .fail_count(fail_count),
    .key_pressed(key_pressed),
    .debounce_active(debounce_active),
    .unlock_pulse(unlock_pulse),
    .bad_pulse(bad_pulse)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0=open, 1=locked, 2=lockout
  bit         m_valid = 1'b0;
  bit         m_prev, m_kp, m_unl, m_bad;
  int         m_deb, m_mode, m_fails, m_left;
  logic [3:0] m_key;
  int         m_dig[$];
  int         m_pass[DIGITS];

  function automatic logic [15:0] m_entry();
    logic [15:0] e;
    e = '1;
    for (int i = 0; i < m_dig.size(); i++)
      e[4*(DIGITS-1-i) +: 4] = 4'(m_dig[i]);
    return e;
  endfunction

  task automatic apply(input logic [3:0] k);
    bit same;
    if (k <= 4'hC) begin
      if (m_dig.size() < DIGITS) m_dig.push_back(int'(k));
    end else if (k == 4'hD) begin
      if (m_dig.size() > 0) void'(m_dig.pop_back());
    end else if (k == 4'hF) begin
      m_dig.delete();
    end else if (m_dig.size() == DIGITS) begin
      if (m_mode == 0) begin
        for (int i = 0; i < DIGITS; i++) m_pass[i] = m_dig[i];
        m_mode = 1;
        m_fails = 0;
      end else begin
        same = 1'b1;
        for (int i = 0; i < DIGITS; i++)
          if (m_dig[i] != m_pass[i]) same = 1'b0;
        if (same) begin
          m_mode = 0;
          m_fails = 0;
          m_unl = 1'b1;
        end else begin
          m_bad = 1'b1;
          if (m_fails + 1 == MAXF) begin
            m_mode = 2;
            m_fails = MAXF;
            m_left = LOCKC;
          end else begin
            m_fails++;
          end
        end
      end
      m_dig.delete();
    end
  endtask

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      m_valid = 1'b1;
      m_prev = 1'b1;
      m_kp = 1'b0;
      m_key = 4'h0;
      m_unl = 1'b0;
      m_bad = 1'b0;
      m_deb = 0;
      m_mode = 0;
      m_fails = 0;
      m_left = 0;
      m_dig.delete();
      for (int i = 0; i < DIGITS; i++)
        m_pass[i] = int'((RC >> (4*(DIGITS-1-i))) & 16'hF);
    end else begin
      acc = m_prev && !validn && (m_deb == 0);
      m_unl = 1'b0;
      m_bad = 1'b0;
      if (m_mode == 2) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 1;
          m_fails = 0;
        end
      end else if (m_kp) begin
        apply(m_key);
      end
      if (acc) begin
        m_deb = DEB;
        m_key = code;
      end else if (m_deb > 0) begin
        m_deb--;
      end
      m_kp = acc;
      m_prev = validn;
    end
  end

  // Event counters observed at the sampling edge
  int kp_n = 0, db_n = 0, unl_n = 0, bad_n = 0, lk_n = 0;
  always @(negedge clk) begin
    if (m_valid) begin
      kp_n  += (key_pressed === 1'b1) ? 1 : 0;
      db_n  += (debounce_active === 1'b1) ? 1 : 0;
      unl_n += (unlock_pulse === 1'b1) ? 1 : 0;
      bad_n += (bad_pulse === 1'b1) ? 1 : 0;
      lk_n  += (lockout === 1'b1) ? 1 : 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic compare();
    chk("entry", 32'(entry), 32'(m_entry()));
    chk("digit_count", 32'(digit_count), 32'(m_dig.size()));
    chk("locked", 32'(locked), 32'(m_mode != 0));
    chk("lockout", 32'(lockout), 32'(m_mode == 2));
    chk("fail_count", 32'(fail_count), 32'(m_fails));
    chk("key_pressed", 32'(key_pressed), 32'(m_kp));
    chk("debounce_active", 32'(debounce_active), 32'(m_deb > 0));
    chk("unlock_pulse", 32'(unlock_pulse), 32'(m_unl));
    chk("bad_pulse", 32'(bad_pulse), 32'(m_bad));
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    code = k;
    validn = 1'b0;
    repeat (2) @(negedge clk);
    validn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic press4(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    for (int i = 3; i >= 0; i--) press(v[4*i +: 4]);
  endtask

  task automatic wait_lockout_end();
    for (int i = 0; i < 40 && lockout === 1'b1; i++) @(negedge clk);
    chk("lockout_timeout", 32'(lockout), 32'(0));
  endtask

  int s0, s1, r, r2, hold, gap;
  int pc[DIGITS];
  logic [3:0] k;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (m_valid) compare();
      end
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset mid-entry
    press(4'h1); press(4'h2); press(4'h3);
    chk("lit_count3", 32'(digit_count), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("lit_rst_entry", 32'(entry), 32'hFFFF);
    chk("lit_rst_count", 32'(digit_count), 32'd0);
    chk("lit_rst_locked", 32'(locked), 32'd0);
    chk("lit_rst_fails", 32'(fail_count), 32'd0);
    chk("lit_rst_pulses",
        32'({key_pressed, unlock_pulse, bad_pulse, debounce_active}),
        32'd0);

    // Bouncing press of 5
    s0 = kp_n;
    s1 = db_n;
    @(negedge clk); code = 4'h5; validn = 1'b0;
    @(negedge clk); validn = 1'b1;
    @(negedge clk); validn = 1'b0;
    @(negedge clk); validn = 1'b1;
    repeat (6) @(negedge clk);
    chk("lit_bounce_pulses", 32'(kp_n - s0), 32'd1);
    chk("lit_bounce_deb", 32'(db_n - s1), 32'd4);
    chk("lit_bounce_entry", 32'(entry), 32'h5FFF);
    press(4'hF);

    // Store 9876 then unlock with a backspace in the middle
    press4(16'h9876); press(4'hE);
    chk("lit_store_locked", 32'(locked), 32'd1);
    chk("lit_store_entry", 32'(entry), 32'hFFFF);
    s0 = unl_n;
    press(4'h9); press(4'h8); press(4'h7); press(4'hD);
    press(4'h7); press(4'h6); press(4'hE);
    chk("lit_unlock_once", 32'(unl_n - s0), 32'd1);
    chk("lit_unlock_locked", 32'(locked), 32'd0);
    chk("lit_unlock_fails", 32'(fail_count), 32'd0);

    // Two wrong codes into lockout
    press4(16'h9876); press(4'hE);
    s0 = bad_n;
    s1 = lk_n;
    press4(16'h1111); press(4'hE);
    chk("lit_fail1", 32'(fail_count), 32'd1);
    press4(16'h2222); press(4'hE);
    chk("lit_lockout_on", 32'(lockout), 32'd1);
    press(4'h9);
    chk("lit_lockout_entry", 32'(entry), 32'hFFFF);
    wait_lockout_end();
    chk("lit_bad_twice", 32'(bad_n - s0), 32'd2);
    chk("lit_lockout_len", 32'(lk_n - s1), 32'd10);
    chk("lit_post_locked", 32'(locked), 32'd1);
    chk("lit_post_fails", 32'(fail_count), 32'd0);

    // Full-entry overflow, clear, short enter
    press4(16'h1234); press(4'h3);
    chk("lit_full_entry", 32'(entry), 32'h1234);
    press(4'hF);
    chk("lit_clear_entry", 32'(entry), 32'hFFFF);
    chk("lit_clear_count", 32'(digit_count), 32'd0);
    chk("lit_clear_locked", 32'(locked), 32'd1);
    press(4'h5); press(4'h6); press(4'hE);
    chk("lit_short_e_entry", 32'(entry), 32'h56FF);
    chk("lit_short_e_count", 32'(digit_count), 32'd2);
    press(4'hF);

    // A good code resets the failure count
    press4(16'h1111); press(4'hE);
    chk("lit_fc1", 32'(fail_count), 32'd1);
    press4(16'h9876); press(4'hE);
    chk("lit_fc0", 32'(fail_count), 32'd0);
    chk("lit_open_again", 32'(locked), 32'd0);
    press4(16'h9876); press(4'hE);
    press4(16'h1111); press(4'hE);
    chk("lit_one_more", 32'(lockout), 32'd0);
    press4(16'h1111); press(4'hE);
    chk("lit_lockout2", 32'(lockout), 32'd1);
    wait_lockout_end();

    // Randomized keys, bounces, resets and correct codes
    for (int it = 0; it < 350; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        @(negedge clk);
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end else if (r < 12) begin
        for (int i = 0; i < DIGITS; i++) pc[i] = m_pass[i];
        press(4'hF);
        for (int i = 0; i < DIGITS; i++) press(4'(pc[i]));
        press(4'hE);
      end else begin
        r2 = $urandom_range(0, 19);
        if (r2 < 11) k = 4'($urandom_range(0, 12));
        else if (r2 < 14) k = 4'hD;
        else if (r2 < 18) k = 4'hE;
        else k = 4'hF;
        hold = $urandom_range(1, 4);
        gap = $urandom_range(0, 7);
        @(negedge clk);
        code = k;
        validn = 1'b0;
        repeat (hold) @(negedge clk);
        validn = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          validn = 1'b0;
          @(negedge clk);
          validn = 1'b1;
        end
        repeat (gap) @(negedge clk);
      end
    end
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
